// File: rtl/tick_bcd_counter.sv
// Multi-digit BCD counter with built-in prescaler tick, programmable wrap and carry pulse.
// Define TICK_BCD_COUNTER_DOWN_EN to build down-counting controlled by up_dn.
module tick_bcd_counter #(
  parameter int DIV    = 24000,
  parameter int DIGITS = 2,
  parameter int TOP    = 59
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  up_dn,
  output logic                  tick,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry
);

  localparam int W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = 4 * DIGITS;

  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  localparam logic [BW-1:0] top_bcd  = to_bcd(TOP);
  localparam logic [W-1:0]  div_last = W'(DIV - 1);

  logic [W-1:0]      div_cnt;
  logic [BW-1:0]     bcd_inc;
  logic [DIGITS-1:0] inc_c;
  logic [DIGITS-1:0] digit_ok;
  logic [BW-1:0]     bcd_step;
  logic [BW-1:0]     load_fixed;
  logic              wrap;
  logic              step;

  assign inc_c[0] = 1'b1;

  // Ripple decimal carry: a digit advances only when every lower digit is 9.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_inc
    logic [3:0] d;
    assign d = bcd[4*gi +: 4];
    assign bcd_inc[4*gi +: 4] = inc_c[gi] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
    assign digit_ok[gi] = (load_val[4*gi +: 4] <= 4'd9);
    if (gi < DIGITS - 1) begin : g_c
      assign inc_c[gi+1] = inc_c[gi] & (d == 4'd9);
    end
  end

`ifdef TICK_BCD_COUNTER_DOWN_EN
  logic [BW-1:0]     bcd_dec;
  logic [DIGITS-1:0] dec_b;

  assign dec_b[0] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
    logic [3:0] d;
    assign d = bcd[4*gi +: 4];
    assign bcd_dec[4*gi +: 4] = dec_b[gi] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
    if (gi < DIGITS - 1) begin : g_b
      assign dec_b[gi+1] = dec_b[gi] & (d == 4'd0);
    end
  end

  always_comb begin
    if (up_dn) begin
      wrap     = (bcd == top_bcd);
      bcd_step = wrap ? '0 : bcd_inc;
    end else begin
      wrap     = (bcd == '0);
      bcd_step = wrap ? top_bcd : bcd_dec;
    end
  end
`else
  logic unused_up_dn;
  assign unused_up_dn = up_dn;

  always_comb begin
    wrap     = (bcd == top_bcd);
    bcd_step = wrap ? '0 : bcd_inc;
  end
`endif

  // Digit-wise validity makes the packed binary compare equal to a decimal compare.
  assign load_fixed = ((&digit_ok) && (load_val <= top_bcd)) ? load_val : '0;
  assign step       = tick & en;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      div_cnt <= '0;
      tick    <= 1'b0;
      bcd     <= '0;
      carry   <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      tick    <= 1'b0;
      bcd     <= '0;
      carry   <= 1'b0;
    end else begin
      if (en) begin
        div_cnt <= (div_cnt == div_last) ? '0 : div_cnt + 1'b1;
      end
      tick  <= en && (div_cnt == div_last);
      carry <= 1'b0;
      if (load) begin
        bcd <= load_fixed;
      end else if (step) begin
        bcd   <= bcd_step;
        carry <= wrap;
      end
    end
  end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed self-checking bench for tick_bcd_counter with DIV=4, DIGITS=2, TOP=59.
module tb_tick_bcd_counter;

  logic       clk;
  logic       res;
  logic       en;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic       up_dn;
  logic       tick;
  logic [7:0] bcd;
  logic       carry;

  int tests;
  int fails;

  tick_bcd_counter #(.DIV(4), .DIGITS(2), .TOP(59)) dut (
    .clk(clk), .res(res), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .up_dn(up_dn),
    .tick(tick), .bcd(bcd), .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clear to realign the prescaler, then load; returns one edge after the load.
  // The first count step then lands 4 edges later.
  task automatic sync_load(input logic [7:0] v);
    en = 1'b1;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    load = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    res = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      tests++;
      if (tick !== 1'b0 || bcd !== 8'h00 || carry !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d tick=%b bcd=%h carry=%b exp 0/00/0", i, tick, bcd, carry);
      end
    end
    res = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc(1);
      tests++;
      if (tick !== 1'b0) begin
        fails++;
        $display("FAIL first_tick_early edge=%0d tick=%b exp 0", i, tick);
      end
    end
    cyc(1);
    tests++;
    if (tick !== 1'b1 || bcd !== 8'h00) begin
      fails++;
      $display("FAIL first_tick edge=4 tick=%b bcd=%h exp 1/00", tick, bcd);
    end
    cyc(1);
    tests++;
    if (bcd !== 8'h01 || tick !== 1'b0) begin
      fails++;
      $display("FAIL first_count bcd=%h tick=%b exp 01/0", bcd, tick);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_up_wrap;
    up_dn = 1'b1;
    sync_load(8'h58);
    tests++;
    if (bcd !== 8'h58) begin fails++; $display("FAIL up_load bcd=%h exp 58", bcd); end
    cyc(4);
    tests++;
    if (bcd !== 8'h59 || carry !== 1'b0) begin
      fails++; $display("FAIL up_59 bcd=%h carry=%b exp 59/0", bcd, carry);
    end
    cyc(4);
    tests++;
    if (bcd !== 8'h00 || carry !== 1'b1) begin
      fails++; $display("FAIL up_wrap bcd=%h carry=%b exp 00/1", bcd, carry);
    end
    cyc(1);
    tests++;
    if (bcd !== 8'h00 || carry !== 1'b0) begin
      fails++; $display("FAIL up_carry_len bcd=%h carry=%b exp 00/0", bcd, carry);
    end
    sync_load(8'h09);
    cyc(4);
    tests++;
    if (bcd !== 8'h10 || carry !== 1'b0) begin
      fails++; $display("FAIL up_digit_carry bcd=%h carry=%b exp 10/0", bcd, carry);
    end
    $display("[TB] test_up_wrap done");
  endtask

  task automatic test_down_wrap;
`ifdef TICK_BCD_COUNTER_DOWN_EN
    up_dn = 1'b0;
    sync_load(8'h01);
    cyc(4);
    tests++;
    if (bcd !== 8'h00 || carry !== 1'b0) begin
      fails++; $display("FAIL down_00 bcd=%h carry=%b exp 00/0", bcd, carry);
    end
    cyc(4);
    tests++;
    if (bcd !== 8'h59 || carry !== 1'b1) begin
      fails++; $display("FAIL down_wrap bcd=%h carry=%b exp 59/1", bcd, carry);
    end
    cyc(1);
    tests++;
    if (carry !== 1'b0) begin fails++; $display("FAIL down_carry_len carry=%b exp 0", carry); end
    sync_load(8'h10);
    cyc(4);
    tests++;
    if (bcd !== 8'h09) begin fails++; $display("FAIL down_borrow bcd=%h exp 09", bcd); end
`else
    up_dn = 1'b0;
    sync_load(8'h20);
    cyc(4);
    tests++;
    if (bcd !== 8'h21) begin fails++; $display("FAIL up_only bcd=%h exp 21", bcd); end
`endif
    up_dn = 1'b1;
    $display("[TB] test_down_wrap done");
  endtask

  task automatic test_invalid_load;
    sync_load(8'h7A);
    tests++;
    if (bcd !== 8'h00) begin fails++; $display("FAIL load_7A bcd=%h exp 00", bcd); end
    sync_load(8'h60);
    tests++;
    if (bcd !== 8'h00) begin fails++; $display("FAIL load_60 bcd=%h exp 00", bcd); end
    sync_load(8'h0F);
    tests++;
    if (bcd !== 8'h00) begin fails++; $display("FAIL load_0F bcd=%h exp 00", bcd); end
    sync_load(8'h59);
    tests++;
    if (bcd !== 8'h59) begin fails++; $display("FAIL load_59 bcd=%h exp 59", bcd); end
    $display("[TB] test_invalid_load done");
  endtask

  task automatic test_priority;
    sync_load(8'h25);
    clr = 1'b1; load = 1'b1; load_val = 8'h33;
    cyc(1);
    clr = 1'b0; load = 1'b0;
    tests++;
    if (bcd !== 8'h00 || tick !== 1'b0) begin
      fails++; $display("FAIL clr_over_load bcd=%h tick=%b exp 00/0", bcd, tick);
    end
    sync_load(8'h12);
    cyc(3);
    tests++;
    if (tick !== 1'b1 || bcd !== 8'h12) begin
      fails++; $display("FAIL pre_load_tick tick=%b bcd=%h exp 1/12", tick, bcd);
    end
    load = 1'b1; load_val = 8'h40;
    cyc(1);
    load = 1'b0;
    tests++;
    if (bcd !== 8'h40 || carry !== 1'b0) begin
      fails++; $display("FAIL load_on_tick bcd=%h carry=%b exp 40/0", bcd, carry);
    end
    cyc(1);
    tests++;
    if (bcd !== 8'h40) begin fails++; $display("FAIL load_no_inc bcd=%h exp 40", bcd); end
    $display("[TB] test_priority done");
  endtask

  task automatic test_enable;
    sync_load(8'h30);
    cyc(1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      tests++;
      if (bcd !== 8'h30 || tick !== 1'b0) begin
        fails++; $display("FAIL en_freeze cyc=%0d bcd=%h tick=%b exp 30/0", i, bcd, tick);
      end
    end
    en = 1'b1;
    cyc(1);
    tests++;
    if (tick !== 1'b0) begin fails++; $display("FAIL resume_phase1 tick=%b exp 0", tick); end
    cyc(1);
    tests++;
    if (tick !== 1'b1 || bcd !== 8'h30) begin
      fails++; $display("FAIL resume_phase2 tick=%b bcd=%h exp 1/30", tick, bcd);
    end
    en = 1'b0;
    cyc(1);
    tests++;
    if (bcd !== 8'h30 || tick !== 1'b0) begin
      fails++; $display("FAIL tick_ignored bcd=%h tick=%b exp 30/0", bcd, tick);
    end
    en = 1'b1;
    cyc(4);
    tests++;
    if (tick !== 1'b1 || bcd !== 8'h30) begin
      fails++; $display("FAIL resume_tick tick=%b bcd=%h exp 1/30", tick, bcd);
    end
    cyc(1);
    tests++;
    if (bcd !== 8'h31) begin fails++; $display("FAIL resume_count bcd=%h exp 31", bcd); end
    $display("[TB] test_enable done");
  endtask

  task automatic test_async_reset;
    sync_load(8'h45);
    cyc(3);
    tests++;
    if (tick !== 1'b1 || bcd !== 8'h45) begin
      fails++; $display("FAIL ares_pre tick=%b bcd=%h exp 1/45", tick, bcd);
    end
    #2 res = 1'b1;
    #1;
    tests++;
    if (bcd !== 8'h00 || tick !== 1'b0 || carry !== 1'b0) begin
      fails++; $display("FAIL ares_mid bcd=%h tick=%b carry=%b exp 00/0/0", bcd, tick, carry);
    end
    res = 1'b0;
    cyc(1);
    sync_load(8'h59);
    cyc(4);
    tests++;
    if (bcd !== 8'h00 || carry !== 1'b1) begin
      fails++; $display("FAIL ares_carry_pre bcd=%h carry=%b exp 00/1", bcd, carry);
    end
    #2 res = 1'b1;
    #1;
    tests++;
    if (carry !== 1'b0 || tick !== 1'b0) begin
      fails++; $display("FAIL ares_carry carry=%b tick=%b exp 0/0", carry, tick);
    end
    res = 1'b0;
    cyc(1);
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_invalid_load();
    test_priority();
    test_enable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
